// File: rtl/sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// The optional signed-overflow output is controlled by SUB_OVERFLOW_EN (see top).
package sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit counter width; never below 1 so the counter vector stays legal.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor4_if.sv
// Operand/result handshake bundle for serial_subtractor4.
// The ovf signal exists only when SUB_OVERFLOW_EN is defined.
interface serial_subtractor4_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bout;
`ifdef SUB_OVERFLOW_EN
    logic             ovf;
`endif

    modport master (
        output start, A, B, Bin,
`ifdef SUB_OVERFLOW_EN
        input  ovf,
`endif
        input  busy, done, D, Bout
    );

    modport slave (
        input  start, A, B, Bin,
`ifdef SUB_OVERFLOW_EN
        output ovf,
`endif
        output busy, done, D, Bout
    );

endinterface

// File: rtl/full_subtractor.sv
// Combinational one-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign d     = w_axb ^ bin;
    assign bout  = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/serial_subtractor4.sv
// Bit-serial subtractor D = A - B - Bin, LSB first, behind a start/busy/done handshake.
// Define SUB_OVERFLOW_EN to add the signed-overflow output ovf.
module serial_subtractor4
    import sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor4_if.slave  bus
);

    localparam int                CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_br;
    logic [WIDTH-1:0]   r_dsh;
    logic [WIDTH-1:0]   r_d;
    logic               r_bout;

    logic               w_accept;
    logic               w_shift;
    logic               w_last;
    logic               w_busy;
    logic               w_done;
    logic               w_d;
    logic               w_bout;

    full_subtractor u_cell (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_shift  = 1'b0;
        w_last   = 1'b0;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_busy  = 1'b1;
                w_shift = 1'b1;
                if (r_cnt == LAST) begin
                    w_last = 1'b1;
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_br   <= 1'b0;
            r_dsh  <= '0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_a    <= bus.A;
            r_b    <= bus.B;
            r_br   <= bus.Bin;
            r_dsh  <= '0;
        end else if (w_shift) begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_a    <= {1'b0, r_a[WIDTH-1:1]};
            r_b    <= {1'b0, r_b[WIDTH-1:1]};
            r_br   <= w_bout;
            r_dsh  <= {w_d, r_dsh[WIDTH-1:1]};
        end
    end

    // Visible result only changes on the final shift, never bit-by-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d    <= '0;
            r_bout <= 1'b0;
        end else if (w_last) begin
            r_d    <= {w_d, r_dsh[WIDTH-1:1]};
            r_bout <= w_bout;
        end
    end

`ifdef SUB_OVERFLOW_EN
    // Operand sign bits are kept aside because the shift regs lose them.
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_msb <= bus.A[WIDTH-1];
                r_b_msb <= bus.B[WIDTH-1];
            end
            if (w_last) begin
                r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
            end
        end
    end

    assign bus.ovf = r_ovf;
`endif

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.D    = r_d;
    assign bus.Bout = r_bout;

endmodule
